// File: rtl/led_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_pkg
// Brief    : Shared mode/direction encodings and the pattern seed function.
// Revision : 1.0 - initial release
// ============================================================================
package led_pattern_pkg;

    localparam logic [1:0] MODE_COUNT  = 2'd0;
    localparam logic [1:0] MODE_WALK   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // Value loaded into the LED register whenever a new mode is entered.
    function automatic logic [31:0] led_seed(input logic [1:0] mode, input int width);
        logic [31:0] seed;
        seed = 32'd0;
        if (width >= 1) begin
            case (mode)
                MODE_WALK, MODE_BOUNCE: seed = 32'd1;
                default:                seed = 32'd0;
            endcase
        end
        return seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : led_prescaler
// Brief    : Clock-enable prescaler producing a terminal-count strobe.
// Revision : 1.0 - initial release
// ============================================================================
module led_prescaler #(
    parameter int PRESCALE_MAX = 524287,
    parameter int PRESCALE_W   = 20
) (
    input  logic clk,
    input  logic NOTRESET,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [PRESCALE_W-1:0] C_MAX = PRESCALE_W'(PRESCALE_MAX);

    logic [PRESCALE_W-1:0] r_cnt;
    logic                  w_at_max;

    assign w_at_max = (r_cnt == C_MAX);
    // A clear on the same cycle suppresses the strobe so mode changes win.
    assign term     = en & ~clr & w_at_max;

    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_at_max) r_cnt <= '0;
            else          r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Brief    : Prescaled multi-pattern LED driver (count/walk/bounce/blink).
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int PRESCALE_MAX = 524287,
    parameter int PRESCALE_W   = 20
) (
    input  logic                clk,
    input  logic                NOTRESET,
    input  logic [1:0]          mode,
    input  logic                hold,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    logic [NUM_LEDS-1:0] r_led;
    logic [1:0]          r_mode_q;
    dir_t                r_dir;
    logic                r_tick;

    logic [NUM_LEDS-1:0] w_led_nxt;
    logic [1:0]          w_mode_nxt;
    dir_t                w_dir_nxt;
    logic                w_tick_nxt;
    logic                w_mode_chg;
    logic                w_term;

    assign w_mode_chg = (mode != r_mode_q);

    led_prescaler #(
        .PRESCALE_MAX (PRESCALE_MAX),
        .PRESCALE_W   (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .NOTRESET (NOTRESET),
        .clr      (w_mode_chg),
        .en       (~hold),
        .term     (w_term)
    );

    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            r_led    <= '0;
            r_mode_q <= MODE_COUNT;
            r_dir    <= DIR_LEFT;
            r_tick   <= 1'b0;
        end else begin
            r_led    <= w_led_nxt;
            r_mode_q <= w_mode_nxt;
            r_dir    <= w_dir_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    always_comb begin
        w_led_nxt  = r_led;
        w_mode_nxt = r_mode_q;
        w_dir_nxt  = r_dir;
        w_tick_nxt = 1'b0;
        if (w_mode_chg) begin
            w_mode_nxt = mode;
            w_led_nxt  = NUM_LEDS'(led_seed(mode, NUM_LEDS));
            w_dir_nxt  = DIR_LEFT;
        end else if (w_term) begin
            w_tick_nxt = 1'b1;
            case (r_mode_q)
                MODE_COUNT: w_led_nxt = r_led + NUM_LEDS'(1);
                MODE_WALK:  w_led_nxt = {r_led[NUM_LEDS-2:0], r_led[NUM_LEDS-1]};
                MODE_BOUNCE: begin
                    // End LEDs reverse direction immediately, so each is lit one step.
                    if (r_dir == DIR_LEFT) begin
                        if (r_led[NUM_LEDS-1]) begin
                            w_dir_nxt = DIR_RIGHT;
                            w_led_nxt = r_led >> 1;
                        end else begin
                            w_led_nxt = r_led << 1;
                        end
                    end else begin
                        if (r_led[0]) begin
                            w_dir_nxt = DIR_LEFT;
                            w_led_nxt = r_led << 1;
                        end else begin
                            w_led_nxt = r_led >> 1;
                        end
                    end
                end
                default:    w_led_nxt = ~r_led;
            endcase
        end
    end

    assign led  = r_led;
    assign tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_gen
// Brief    : Directed self-checking bench, 4 LEDs, step every 4 clocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       NOTRESET;
    logic [1:0] mode;
    logic       hold;
    logic [3:0] led;
    logic       tick;
    logic [3:0] led0;
    logic       tick0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(.NUM_LEDS(4), .PRESCALE_MAX(3), .PRESCALE_W(2)) u_dut (
        .clk(clk), .NOTRESET(NOTRESET), .mode(mode), .hold(hold), .led(led), .tick(tick)
    );

    // Second instance exercises the step-every-clock corner.
    led_pattern_gen #(.NUM_LEDS(4), .PRESCALE_MAX(0), .PRESCALE_W(1)) u_dut0 (
        .clk(clk), .NOTRESET(NOTRESET), .mode(mode), .hold(hold), .led(led0), .tick(tick0)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] e;
        logic [3:0] e0;
        int k;
        NOTRESET = 1'b0;
        mode     = 2'd0;
        hold     = 1'b0;
        repeat (2) step();
        if (led !== 4'b0000 || tick !== 1'b0) begin
            $display("FAIL reset: led=%b tick=%b want led=0000 tick=0", led, tick);
            n_fail++;
        end
        n_checks++;
        if (led0 !== 4'b0000 || tick0 !== 1'b0) begin
            $display("FAIL reset_pm0: led=%b tick=%b want led=0000 tick=0", led0, tick0);
            n_fail++;
        end
        n_checks++;
        NOTRESET = 1'b1;
        k = 0;
        for (int s = 1; s <= 16; s++) begin
            for (int c = 1; c <= 4; c++) begin
                step();
                k++;
                e0 = 4'(k);
                if (led0 !== e0 || tick0 !== 1'b1) begin
                    $display("FAIL pm0_count: led=%b tick=%b want led=%b tick=1", led0, tick0, e0);
                    n_fail++;
                end
                n_checks++;
                if (c < 4) begin
                    e = 4'(s - 1);
                    if (led !== e || tick !== 1'b0) begin
                        $display("FAIL count_wait: led=%b tick=%b want led=%b tick=0", led, tick, e);
                        n_fail++;
                    end
                end else begin
                    e = 4'(s);
                    if (led !== e || tick !== 1'b1) begin
                        $display("FAIL count_step: led=%b tick=%b want led=%b tick=1", led, tick, e);
                        n_fail++;
                    end
                end
                n_checks++;
            end
        end
    endtask

    task automatic test_walk();
        logic [3:0] exp_w [4];
        exp_w = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mode = 2'd1;
        step();
        if (led !== 4'b0001 || tick !== 1'b0) begin
            $display("FAIL walk_seed: led=%b tick=%b want led=0001 tick=0", led, tick);
            n_fail++;
        end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            repeat (3) step();
            if (tick !== 1'b0) begin
                $display("FAIL walk_wait: tick=%b want 0", tick);
                n_fail++;
            end
            n_checks++;
            step();
            if (led !== exp_w[i] || tick !== 1'b1) begin
                $display("FAIL walk_step: led=%b tick=%b want led=%b tick=1", led, tick, exp_w[i]);
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_b [7];
        exp_b = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        mode = 2'd2;
        step();
        if (led !== 4'b0001 || tick !== 1'b0) begin
            $display("FAIL bounce_seed: led=%b tick=%b want led=0001 tick=0", led, tick);
            n_fail++;
        end
        n_checks++;
        for (int i = 0; i < 7; i++) begin
            repeat (4) step();
            if (led !== exp_b[i] || tick !== 1'b1) begin
                $display("FAIL bounce_step: led=%b tick=%b want led=%b tick=1", led, tick, exp_b[i]);
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_hold();
        mode = 2'd0;
        step();
        if (led !== 4'b0000) begin
            $display("FAIL hold_seed: led=%b want 0000", led);
            n_fail++;
        end
        n_checks++;
        repeat (20) step();
        if (led !== 4'b0101 || tick !== 1'b1) begin
            $display("FAIL hold_setup: led=%b tick=%b want led=0101 tick=1", led, tick);
            n_fail++;
        end
        n_checks++;
        step();
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (led !== 4'b0101 || tick !== 1'b0) begin
                $display("FAIL hold_frozen: led=%b tick=%b want led=0101 tick=0", led, tick);
                n_fail++;
            end
            n_checks++;
        end
        hold = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (led !== 4'b0101 || tick !== 1'b0) begin
                $display("FAIL hold_resume_wait: led=%b tick=%b want led=0101 tick=0", led, tick);
                n_fail++;
            end
            n_checks++;
        end
        step();
        if (led !== 4'b0110 || tick !== 1'b1) begin
            $display("FAIL hold_resume_step: led=%b tick=%b want led=0110 tick=1", led, tick);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_mode_change();
        repeat (2) step();
        mode = 2'd3;
        step();
        if (led !== 4'b0000 || tick !== 1'b0) begin
            $display("FAIL blink_seed: led=%b tick=%b want led=0000 tick=0", led, tick);
            n_fail++;
        end
        n_checks++;
        repeat (3) step();
        if (led !== 4'b0000 || tick !== 1'b0) begin
            $display("FAIL blink_restart: led=%b tick=%b want led=0000 tick=0", led, tick);
            n_fail++;
        end
        n_checks++;
        step();
        if (led !== 4'b1111 || tick !== 1'b1) begin
            $display("FAIL blink_step: led=%b tick=%b want led=1111 tick=1", led, tick);
            n_fail++;
        end
        n_checks++;
        repeat (3) step();
        mode = 2'd0;
        step();
        if (led !== 4'b0000 || tick !== 1'b0) begin
            $display("FAIL collision: led=%b tick=%b want led=0000 tick=0", led, tick);
            n_fail++;
        end
        n_checks++;
        repeat (3) step();
        if (tick !== 1'b0) begin
            $display("FAIL collision_wait: tick=%b want 0", tick);
            n_fail++;
        end
        n_checks++;
        step();
        if (led !== 4'b0001 || tick !== 1'b1) begin
            $display("FAIL collision_step: led=%b tick=%b want led=0001 tick=1", led, tick);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_async_reset();
        mode = 2'd2;
        step();
        repeat (8) step();
        if (led !== 4'b0100 || tick !== 1'b1) begin
            $display("FAIL areset_setup: led=%b tick=%b want led=0100 tick=1", led, tick);
            n_fail++;
        end
        n_checks++;
        #2;
        NOTRESET = 1'b0;
        #1;
        if (led !== 4'b0000 || tick !== 1'b0) begin
            $display("FAIL areset_immediate: led=%b tick=%b want led=0000 tick=0", led, tick);
            n_fail++;
        end
        n_checks++;
        @(negedge clk);
        NOTRESET = 1'b1;
        step();
        if (led !== 4'b0001 || tick !== 1'b0) begin
            $display("FAIL areset_reseed: led=%b tick=%b want led=0001 tick=0", led, tick);
            n_fail++;
        end
        n_checks++;
        repeat (4) step();
        if (led !== 4'b0010 || tick !== 1'b1) begin
            $display("FAIL areset_step: led=%b tick=%b want led=0010 tick=1", led, tick);
            n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_walk();
        test_bounce();
        test_hold();
        test_mode_change();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
